// File: rtl/icache_direct_pkg.sv
// rtl/icache_direct_pkg.sv - shared geometry constants and FSM encoding for the direct-mapped icache
package icache_direct_pkg;

  // Default cache geometry, shared with the memory controller's IF port.
  localparam int ICACHE_LINE_LEN  = 64;
  localparam int ICACHE_LINE_WID  = 8 * ICACHE_LINE_LEN;
  localparam int ICACHE_NUM_LINES = 16;
  localparam int ICACHE_ADDR_WID  = 32;

  // Address split: [tag | idx | off | 2'b byte-in-word].
  localparam int ICACHE_OFF_WID = $clog2(ICACHE_LINE_LEN) - 2;
  localparam int ICACHE_IDX_WID = $clog2(ICACHE_NUM_LINES);
  localparam int ICACHE_TAG_WID = ICACHE_ADDR_WID - $clog2(ICACHE_LINE_LEN) - ICACHE_IDX_WID;

  typedef enum logic [1:0] {
    ICACHE_IDLE  = 2'd0,
    ICACHE_MISS  = 2'd1,
    ICACHE_REPLY = 2'd2
  } icache_state_e;

  // Number of word-select bits for a line of the given byte length.
  function automatic int word_off_wid(input int line_bytes);
    return $clog2(line_bytes) - 2;
  endfunction

endpackage

// File: rtl/icache_word_sel.sv
// rtl/icache_word_sel.sv - picks one little-endian 32-bit word out of a cache line
module icache_word_sel
  import icache_direct_pkg::*;
#(
  parameter int LINE_BYTES = ICACHE_LINE_LEN,
  parameter int OFF_W      = word_off_wid(LINE_BYTES)
) (
  input  logic [8*LINE_BYTES-1:0] line,
  input  logic [OFF_W-1:0]        off,
  output logic [31:0]             word
);

  // Word n occupies line bytes 4n..4n+3, lowest byte in the low bits.
  always_comb begin
    word = line[{off, 5'b00000} +: 32];
  end

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped instruction cache with non-abortable line fill
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int LINE_BYTES = ICACHE_LINE_LEN,
  parameter int NUM_LINES  = ICACHE_NUM_LINES,
  parameter int ADDR_W     = ICACHE_ADDR_WID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    fetch_en,
  input  logic [ADDR_W-1:0]       fetch_pc,
  output logic                    fetch_done,
  output logic [31:0]             fetch_inst,
  output logic                    mem_if_en,
  output logic [ADDR_W-1:0]       mem_if_pc,
  input  logic                    mem_if_done,
  input  logic [8*LINE_BYTES-1:0] mem_if_data
);

  localparam int LINE_OFF_W = $clog2(LINE_BYTES);
  localparam int OFF_W      = LINE_OFF_W - 2;
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int TAG_W      = ADDR_W - LINE_OFF_W - IDX_W;
  localparam int LINE_W     = 8 * LINE_BYTES;

  icache_state_e state, state_nxt;

  logic                 flushed, flushed_nxt;
  logic [ADDR_W-1:0]    req_pc;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr [NUM_LINES];

  // Lookup fields of the live fetch address and of the latched miss address.
  logic [IDX_W-1:0] idx_f, idx_r;
  logic [TAG_W-1:0] tag_f, tag_r;
  logic [OFF_W-1:0] off_f, off_r;

  assign idx_f = fetch_pc[LINE_OFF_W +: IDX_W];
  assign tag_f = fetch_pc[ADDR_W-1 -: TAG_W];
  assign off_f = fetch_pc[2 +: OFF_W];
  assign idx_r = req_pc[LINE_OFF_W +: IDX_W];
  assign tag_r = req_pc[ADDR_W-1 -: TAG_W];
  assign off_r = req_pc[2 +: OFF_W];

  // Byte-in-word address bits never matter for a word fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], req_pc[1:0]};

  logic hit;
  assign hit = valid_q[idx_f] && (tag_arr[idx_f] == tag_f);

  // One word selector serves both the hit path (live pc) and the reply path (latched pc).
  logic [LINE_W-1:0] sel_line;
  logic [OFF_W-1:0]  sel_off;
  logic [31:0]       sel_word;

  // Steer the selector to the just-filled line while replying, else to the looked-up line.
  always_comb begin
    sel_line = data_arr[idx_f];
    sel_off  = off_f;
    if (state == ICACHE_REPLY) begin
      sel_line = data_arr[idx_r];
      sel_off  = off_r;
    end
  end

  icache_word_sel #(
    .LINE_BYTES (LINE_BYTES),
    .OFF_W      (OFF_W)
  ) u_word_sel (
    .line (sel_line),
    .off  (sel_off),
    .word (sel_word)
  );

  logic do_lookup, hit_reply, start_miss, fill, give_reply;

  // Next-state and per-cycle actions; a flush during a miss only suppresses the reply.
  always_comb begin
    state_nxt   = state;
    flushed_nxt = flushed;
    do_lookup   = 1'b0;
    hit_reply   = 1'b0;
    start_miss  = 1'b0;
    fill        = 1'b0;
    give_reply  = 1'b0;
    case (state)
      ICACHE_IDLE: begin
        if (fetch_en && !rollback) begin
          do_lookup = 1'b1;
          if (hit) begin
            hit_reply = 1'b1;
          end else begin
            start_miss = 1'b1;
            state_nxt  = ICACHE_MISS;
          end
        end
      end
      ICACHE_MISS: begin
        if (mem_if_done) begin
          fill        = 1'b1;
          flushed_nxt = 1'b0;
          state_nxt   = (flushed || rollback) ? ICACHE_IDLE : ICACHE_REPLY;
        end else if (rollback) begin
          flushed_nxt = 1'b1;
        end
      end
      ICACHE_REPLY: begin
        give_reply = !rollback;
        state_nxt  = ICACHE_IDLE;
      end
      default: begin
        state_nxt = ICACHE_IDLE;
      end
    endcase
  end

  // FSM state register; rdy low freezes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ICACHE_IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  // Output, request and valid registers; fetch_done is a single-cycle pulse unless frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_done <= 1'b0;
      fetch_inst <= 32'd0;
      mem_if_en  <= 1'b0;
      mem_if_pc  <= '0;
      req_pc     <= '0;
      flushed    <= 1'b0;
      valid_q    <= '0;
    end else if (rdy) begin
      fetch_done <= hit_reply || give_reply;
      flushed    <= flushed_nxt;
      if (hit_reply || give_reply) begin
        fetch_inst <= sel_word;
      end
      if (do_lookup) begin
        req_pc <= fetch_pc;
      end
      if (start_miss) begin
        mem_if_en <= 1'b1;
        mem_if_pc <= {fetch_pc[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
      end
      if (fill) begin
        mem_if_en      <= 1'b0;
        valid_q[idx_r] <= 1'b1;
      end
    end
  end

  // Line data and tag storage; left unreset since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      data_arr[idx_r] <= mem_if_data;
      tag_arr[idx_r]  <= tag_r;
    end
  end

endmodule
